iot_tty_out: RTL and testbench

- Teleprinter output device (device code 04) on the IOT bus.
- Responds to the IOT distributor's strobe for the TSF/TCF/TPC/TLS micro-operations.
- Captures the 8-bit data the CPU drives out from AC[7:0] and serializes it as an asynchronous frame on a TX line.
- Maintains the device flag and returns the skip indication to the distributor. It is the receiving end of the CPU dataout path.

---
 rtl/iot_tty_out_if.sv | 22 ++
 rtl/iot_tty_out.sv | 184 ++++++++++++++++++
 tb/tb_iot_tty_out.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/iot_tty_out_if.sv
// IOT bus slice between the distributor/CPU (master) and the teleprinter
// output device (slave). Clock and reset travel as plain ports.
interface iot_tty_out_if;
  logic       iot_strobe;
  logic [2:0] iot_func;
  logic [7:0] dataout;
  logic       skip;
  logic       flag;
  logic       busy;
  logic       overrun;
  logic       tx;

  modport master (
    output iot_strobe, iot_func, dataout,
    input  skip, flag, busy, overrun, tx
  );

  modport slave (
    input  iot_strobe, iot_func, dataout,
    output skip, flag, busy, overrun, tx
  );
endinterface

// File: rtl/iot_tty_out.sv
// Teleprinter output device (device code 04). Decodes TSF/TCF/TPC/TLS from
// the distributor strobe, serialises the latched AC[7:0] byte LSB first as
// an asynchronous frame on tx, and keeps the character-done flag.
// Optional even-parity bit after the data: define TTY_PARITY_EN.
module iot_tty_out #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 2
) (
  input logic          clock,
  input logic          resetN,
  iot_tty_out_if.slave bus
);

  localparam int              TW    = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]   TLOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TTY_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state_q, state_n;
  logic [TW-1:0] timer_q, timer_n;
  logic [2:0]    idx_q, idx_n;
  logic [7:0]    shift_q, shift_n;
  logic          tx_q, tx_n;
  logic          busy_q, busy_n;
  logic          flag_q, flag_n;
  logic          skip_q, skip_n;
  logic          overrun_q, overrun_n;
`ifdef TTY_PARITY_EN
  logic          parity_q, parity_n;
`endif

  logic tsf, tcf, tpc, bit_end;

  assign tsf     = bus.iot_strobe & bus.iot_func[0];
  assign tcf     = bus.iot_strobe & bus.iot_func[1];
  assign tpc     = bus.iot_strobe & bus.iot_func[2];
  assign bit_end = (timer_q == '0);

  // Next-state, bit timing, shifter and flag/skip/overrun decode.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a variable unassigned and no latch is inferred.
    state_n   = state_q;
    timer_n   = timer_q;
    idx_n     = idx_q;
    shift_n   = shift_q;
    tx_n      = tx_q;
    busy_n    = busy_q;
    flag_n    = flag_q;
    skip_n    = 1'b0;
    overrun_n = 1'b0;
`ifdef TTY_PARITY_EN
    parity_n  = parity_q;
`endif

    // skip reflects the flag as it stood in the strobe cycle.
    if (tsf) skip_n = flag_q;
    if (tcf) flag_n = 1'b0;
    // A print request while a frame is running is dropped.
    if (tpc && state_q != IDLE) overrun_n = 1'b1;

    // Running bit timer; terminal branches below override the reload.
    if (state_q != IDLE) timer_n = bit_end ? TLOAD : timer_q - 1'b1;

    unique case (state_q)
      IDLE: begin
        if (tpc) begin
          shift_n = bus.dataout;
`ifdef TTY_PARITY_EN
          parity_n = ^bus.dataout;
`endif
          state_n = START;
          busy_n  = 1'b1;
          tx_n    = 1'b0;
          timer_n = TLOAD;
          idx_n   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          tx_n    = shift_q[0];
          idx_n   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            idx_n = '0;
`ifdef TTY_PARITY_EN
            state_n = PARITY;
            tx_n    = parity_q;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            shift_n = shift_q >> 1;
            tx_n    = shift_q[1];
            idx_n   = idx_q + 3'd1;
          end
        end
      end
`ifdef TTY_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          tx_n    = 1'b1;
          idx_n   = '0;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (idx_q == LAST_STOP) begin
            // Completion set is applied after any TCF clear, so it wins.
            state_n = IDLE;
            busy_n  = 1'b0;
            flag_n  = 1'b1;
            idx_n   = '0;
            timer_n = '0;
          end else begin
            idx_n = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        tx_n    = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: reset is sampled only on the clock edge; the shift register is
    // cleared as well, keeping the datapath deterministic after reset.
    if (!resetN) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      flag_q    <= 1'b0;
      skip_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef TTY_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments here; the comb block uses blocking.
      state_q   <= state_n;
      timer_q   <= timer_n;
      idx_q     <= idx_n;
      shift_q   <= shift_n;
      tx_q      <= tx_n;
      busy_q    <= busy_n;
      flag_q    <= flag_n;
      skip_q    <= skip_n;
      overrun_q <= overrun_n;
`ifdef TTY_PARITY_EN
      parity_q  <= parity_n;
`endif
    end
  end

  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.flag    = flag_q;
  assign bus.skip    = skip_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_iot_tty_out.sv
// Self-checking bench for iot_tty_out with CLKS_PER_BIT=4, STOP_BITS=2.
// The expected line waveform is built from the frame format (start, data LSB
// first, optional even parity, stop bits) expanded to bit times.
module tb_iot_tty_out;
  localparam int CPB   = 4;
  localparam int STOPB = 2;
`ifdef TTY_PARITY_EN
  localparam int NBITS = 1 + 8 + 1 + STOPB;
`else
  localparam int NBITS = 1 + 8 + STOPB;
`endif
  localparam int FRAME = NBITS * CPB;

  logic clock = 1'b0;
  logic resetN;
  int   checks = 0;
  int   errors = 0;
  logic m_flag;
  logic exp_tx [0:FRAME-1];

  iot_tty_out_if bus ();

  iot_tty_out #(.CLKS_PER_BIT(CPB), .STOP_BITS(STOPB)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  // Reference frame: list of bit values, each held for CPB cycles.
  task automatic build_frame(input logic [7:0] d);
    logic bits[$];
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef TTY_PARITY_EN
    bits.push_back(^d);
`endif
    for (int i = 0; i < STOPB; i++) bits.push_back(1'b1);
    for (int b = 0; b < NBITS; b++)
      for (int c = 0; c < CPB; c++) exp_tx[b*CPB + c] = bits[b];
  endtask

  // One-cycle strobe issued at a negedge; returns at the following negedge.
  task automatic strobe(input logic [2:0] f, input logic [7:0] d);
    bus.iot_strobe = 1'b1;
    bus.iot_func   = f;
    bus.dataout    = d;
    @(negedge clock);
    bus.iot_strobe = 1'b0;
    bus.iot_func   = 3'b000;
    bus.dataout    = $urandom;
  endtask

  // Start a frame with func sf, optionally inject strobe ef in cycle ev,
  // and check every cycle through the first idle cycle.
  task automatic frame_check(input string name, input logic [7:0] d,
                             input logic [2:0] sf, input int ev,
                             input logic [2:0] ef, input logic [7:0] ed);
    logic skip_exp = 1'b0;
    logic exp_t, exp_b, exp_o, exp_s;
    build_frame(d);
    strobe(sf, d);
    if (sf[1]) m_flag = 1'b0;
    for (int k = 1; k <= FRAME + 1; k++) begin
      exp_t = (k <= FRAME) ? exp_tx[k-1] : 1'b1;
      exp_b = (k <= FRAME);
      exp_o = ef[2] && (k == ev + 1);
      exp_s = ef[0] && (k == ev + 1) && skip_exp;
      checks++;
      if (bus.tx !== exp_t) begin
        errors++;
        $display("FAIL %s tx cycle %0d: got %b want %b", name, k, bus.tx, exp_t);
      end
      checks++;
      if (bus.busy !== exp_b) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b want %b", name, k, bus.busy, exp_b);
      end
      checks++;
      if (bus.flag !== m_flag) begin
        errors++;
        $display("FAIL %s flag cycle %0d: got %b want %b", name, k, bus.flag, m_flag);
      end
      checks++;
      if (bus.overrun !== exp_o) begin
        errors++;
        $display("FAIL %s overrun cycle %0d: got %b want %b", name, k, bus.overrun, exp_o);
      end
      checks++;
      if (bus.skip !== exp_s) begin
        errors++;
        $display("FAIL %s skip cycle %0d: got %b want %b", name, k, bus.skip, exp_s);
      end
      if (k == FRAME + 1) break;
      if (k == ev) begin
        skip_exp = m_flag;
        strobe(ef, ed);
        if (ef[1]) m_flag = 1'b0;
      end else begin
        @(negedge clock);
      end
      if (k == FRAME) m_flag = 1'b1;
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({bus.tx, bus.flag, bus.busy, bus.skip, bus.overrun} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_state: got %b want 10000",
               {bus.tx, bus.flag, bus.busy, bus.skip, bus.overrun});
    end
    resetN = 1'b1;
    m_flag = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_midframe();
    strobe(3'b100, 8'h00);
    repeat (7) @(negedge clock);
    resetN = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      checks++;
      if ({bus.tx, bus.flag, bus.busy, bus.skip} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_midframe %0d: got %b want 1000", k,
                 {bus.tx, bus.flag, bus.busy, bus.skip});
      end
    end
    resetN = 1'b1;
    m_flag = 1'b0;
    for (int k = 0; k < 3 * CPB; k++) begin
      @(negedge clock);
      checks++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle %0d: got tx=%b busy=%b want 1 0", k, bus.tx, bus.busy);
      end
    end
  endtask

  task automatic test_tsf();
    strobe(3'b010, 8'h00);
    m_flag = 1'b0;
    // TSF mid-frame with flag clear, then observe completion.
    frame_check("tsf_mid", 8'h5A, 3'b100, 10, 3'b001, 8'h00);
    strobe(3'b001, 8'h00);
    checks++;
    if (bus.skip !== 1'b1) begin
      errors++;
      $display("FAIL tsf_done: got %b want 1", bus.skip);
    end
    @(negedge clock);
    checks++;
    if (bus.skip !== 1'b0) begin
      errors++;
      $display("FAIL tsf_done_pulse: got %b want 0", bus.skip);
    end
    strobe(3'b010, 8'h00);
    m_flag = 1'b0;
    strobe(3'b001, 8'h00);
    checks++;
    if (bus.skip !== 1'b0 || bus.flag !== 1'b0) begin
      errors++;
      $display("FAIL tsf_after_tcf: got skip=%b flag=%b want 0 0", bus.skip, bus.flag);
    end
  endtask

  task automatic test_nop();
    logic f0;
    f0 = bus.flag;
    strobe(3'b000, 8'hFF);
    for (int k = 0; k < CPB; k++) begin
      checks++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.flag !== f0) begin
        errors++;
        $display("FAIL nop %0d: got tx=%b busy=%b flag=%b want 1 0 %b",
                 k, bus.tx, bus.busy, bus.flag, f0);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_random();
    logic [2:0] ftab [0:5];
    ftab[0] = 3'b001; ftab[1] = 3'b010; ftab[2] = 3'b100;
    ftab[3] = 3'b000; ftab[4] = 3'b110; ftab[5] = 3'b011;
    for (int i = 0; i < 6; i++) begin
      frame_check("random", 8'($urandom), ($urandom_range(1) != 0) ? 3'b110 : 3'b100,
                  $urandom_range(FRAME, 2), ftab[$urandom_range(5)], 8'($urandom));
      repeat ($urandom_range(3)) @(negedge clock);
    end
  endtask

  initial begin
    bus.iot_strobe = 1'b0;
    bus.iot_func   = 3'b000;
    bus.dataout    = 8'h00;
    @(negedge clock);
    test_reset();
    test_reset_midframe();
    frame_check("tls_41", 8'h41, 3'b110, 0, 3'b000, 8'h00);
    test_tsf();
    frame_check("overrun_55", 8'h55, 3'b100, 6, 3'b100, 8'hAA);
    frame_check("race_tcf", 8'hC3, 3'b110, FRAME, 3'b010, 8'h00);
    test_nop();
`ifdef TTY_PARITY_EN
    frame_check("parity_07", 8'h07, 3'b110, 0, 3'b000, 8'h00);
    frame_check("parity_03", 8'h03, 3'b110, 0, 3'b000, 8'h00);
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
